element_assembler: RTL
======================

Name: element_assembler

Overview:
- Byte-to-element packer directly upstream of element_controller.
- Consumes the 8-bit receive stream (rx_data/rx_valid from the UART receiver) and packs ELEMENT_WIDTH consecutive bytes, MSB first, into one element.
- Presents each element with a one-cycle element_ready strobe in exactly the format element_controller samples.
- Provides inter-byte timeout resync and a synchronous flush, so a dropped byte cannot misalign every following element.

Parameters:
- ELEMENT_WIDTH, 3, bytes per element; legal range 1..8.
- TIMEOUT_CYCLES, 100000, idle clk cycles inside a partial element before it is discarded; must be >= 2.
- COUNT_WIDTH, 16, width of element_count.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per byte; may be asserted on back-to-back cycles.
- flush  in  1  synchronous discard of any partial element.
- element  out  ELEMENT_WIDTH*8  last completed element; feeds element_controller.element.
- element_ready  out  1  one-cycle pulse; element is valid on this cycle and held afterwards.
- state  out  2  0=IDLE, 1=COLLECT, 2=EMIT.
- element_count  out  COUNT_WIDTH  elements emitted since reset; wraps modulo 2^COUNT_WIDTH.
- timeout_error  out  1  sticky; set when a partial element is discarded by timeout.

Behaviour:
- Reset (reset=0, asynchronous): all registers clear. state=IDLE, element=0, element_ready=0, element_count=0, timeout_error=0, byte index=0, shift register=0, timeout counter=0.
- Byte capture: on rx_valid, shift <= {shift[ELEMENT_WIDTH*8-9:0], rx_data} and index increments. The first byte received becomes bits [ELEMENT_WIDTH*8-1 : ELEMENT_WIDTH*8-8].
- Completion: rx_valid with index=ELEMENT_WIDTH-1, then on the next cycle:
  - element <= completed word;
  - element_ready=1 for exactly that cycle;
  - state=EMIT;
  - element_count increments;
  - index returns to 0.
  - Latency: element_ready is asserted 1 cycle after the last byte's rx_valid.
- element holds its value until the next completion; it does not change on flush, timeout or partial bytes.
- IDLE: index=0. rx_valid -> COLLECT, index=1. For ELEMENT_WIDTH=1, rx_valid goes directly to EMIT.
- COLLECT:
  - rx_valid resets the timeout counter.
  - Each cycle without rx_valid increments the timeout counter.
  - Counter reaching TIMEOUT_CYCLES-1 without a byte -> discard partial element, set timeout_error, go to IDLE.
- EMIT: lasts one cycle.
  - rx_valid in this cycle is accepted as byte 0 of the next element (-> COLLECT, index=1); no byte is ever dropped.
  - Otherwise -> IDLE.
- Back-to-back bytes: sustained throughput is one element per ELEMENT_WIDTH cycles. Pulses are never merged.
- flush (priority over rx_valid and timeout):
  - partial element and timeout counter discarded, index=0, timeout_error cleared, state -> IDLE next cycle;
  - an rx_valid in the same cycle is dropped;
  - flush in the cycle that would emit suppresses the emission.
- Timeout and rx_valid in the same cycle: the byte wins; no timeout.
- element_count wraps from all-ones to 0 without a flag.
- Reset mid-element: partial data is lost; the next byte after release is byte 0.

Decomposition:
- Shared package/header vm_defs: BYTE_WIDTH=8; state encodings ST_IDLE=0, ST_COLLECT=1, ST_EMIT=2; element width expression ELEMENT_WIDTH*8, shared with element_controller.
- One natural sub-module: idle_timeout_counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES; counter width $clog2(TIMEOUT_CYCLES).
- Packing, index and FSM stay in the top module.

Test Plan:
- Bench setup: ELEMENT_WIDTH=3, TIMEOUT_CYCLES=16.
- Reset: hold reset=0 for 5 cycles -> element=0, element_ready=0, element_count=0, timeout_error=0, state=0; the same values appear immediately on an asynchronous assert mid-cycle.
- Spaced bytes: 0x69,0x69,0x69, one byte every 2 cycles -> single element_ready pulse 1 cycle after the third byte, element=0x696969, element_count=1; element is still 0x696969 10 cycles later.
- Back-to-back: 0x01,0x00,0x40,0x00,0xAB,0x00 on consecutive cycles -> pulses exactly 3 cycles apart, elements 0x010040 then 0x00AB00, element_count=2, no byte lost across EMIT.
- Timeout: 0xCD, 0x69, then 16 idle cycles -> timeout_error=1, state=IDLE, no pulse, element unchanged. Then 0x00,0x17,0x38 -> element=0x001738.
- Flush: 0xAB,0x00, then flush together with rx_valid of 0xFF -> no pulse, timeout_error=0. Then 0x00,0x07,0x00 -> element=0x000700.
- Wrap: COUNT_WIDTH=2, send 5 elements -> element_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/element_assembler_pkg.sv
// Shared definitions for the byte-to-element packer and its consumers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: byte width, FSM state encoding (shared with element_controller),
// and the element bit-width helper.
package element_assembler_pkg;

    localparam int BYTE_WIDTH = 8;

    // Encoding is visible on the state output port, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    // Element width in bits; element_controller uses the same expression.
    function automatic int elem_bits(input int element_width);
        return element_width * BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/element_assembler_if.sv
// Bundle of the receive byte stream and the packed-element result signals.
// Latency: n/a (wiring only).
// Backpressure: none; the byte stream is strobe-only and cannot be stalled.
//
// master: byte source (drives rx_data/rx_valid/flush, observes results).
// slave : element_assembler (consumes bytes, drives element and status).
interface element_assembler_if #(
    parameter int ELEMENT_WIDTH = 3,
    parameter int COUNT_WIDTH   = 16
);
    import element_assembler_pkg::*;

    logic [BYTE_WIDTH-1:0]               rx_data;
    logic                                rx_valid;
    logic                                flush;
    logic [ELEMENT_WIDTH*BYTE_WIDTH-1:0] element;
    logic                                element_ready;
    logic [1:0]                          state;
    logic [COUNT_WIDTH-1:0]              element_count;
    logic                                timeout_error;

    modport master (
        output rx_data, rx_valid, flush,
        input  element, element_ready, state, element_count, timeout_error
    );

    modport slave (
        input  rx_data, rx_valid, flush,
        output element, element_ready, state, element_count, timeout_error
    );

endinterface

// File: rtl/element_assembler_idle_timeout_counter.sv
// Counts idle cycles inside a partial element and flags expiry.
// Latency: o_expired is combinational on the cycle the count sits at TIMEOUT_CYCLES-1.
// Backpressure: none.
//
// Ports: clk, reset (async active-low), i_clear (zero the count, highest
// priority), i_enable (count this cycle), o_expired (timeout reached now).
module idle_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);
    // The Nth consecutive idle cycle is the one that expires.
    assign o_expired = i_enable & ~i_clear & w_at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            // Wrap to zero on expiry so a stale count never leaks into the
            // next partial element.
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/element_assembler.sv
// Packs ELEMENT_WIDTH consecutive received bytes (MSB first) into one element.
// Latency: element_ready pulses 1 cycle after the rx_valid of the last byte.
// Backpressure: none; every byte is accepted, including during the EMIT cycle.
//
// Ports: clk, reset (async active-low), bus (slave modport): rx_data/rx_valid
// byte strobe in, flush in, element/element_ready/state/element_count/
// timeout_error out.
module element_assembler
    import element_assembler_pkg::*;
#(
    parameter int ELEMENT_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    element_assembler_if.slave  bus
);

    localparam int ELEM_BITS = elem_bits(ELEMENT_WIDTH);
    localparam int IDX_W     = (ELEMENT_WIDTH > 1) ? $clog2(ELEMENT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMENT_WIDTH - 1);

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_index, w_index_nxt;
    logic [ELEM_BITS-1:0]   r_shift, w_shift_nxt;
    logic [ELEM_BITS-1:0]   r_element;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_timeout_error;

    logic [ELEM_BITS-1:0]   w_word;
    logic                   w_capture;
    logic                   w_complete;
    logic                   w_tmo_enable;
    logic                   w_tmo_clear;
    logic                   w_tmo_expired;

    // flush beats rx_valid, so a byte arriving with flush is never captured.
    assign w_capture  = bus.rx_valid & ~bus.flush;
    assign w_complete = w_capture & (r_index == LAST_IDX);

    // Shift-in form also covers ELEMENT_WIDTH=1 (the shift pushes everything out).
    assign w_word = (r_shift << BYTE_WIDTH) | ELEM_BITS'(bus.rx_data);

    // The idle counter only runs while a partial element is waiting; any byte
    // or flush restarts it, which also makes a byte win over a same-cycle timeout.
    assign w_tmo_enable = (r_state == ST_COLLECT) & ~bus.rx_valid & ~bus.flush;
    assign w_tmo_clear  = (r_state != ST_COLLECT) | bus.rx_valid | bus.flush;

    idle_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timeout_counter (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_enable),
        .o_expired (w_tmo_expired)
    );

    // FSM state register together with the packing index and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic. Bytes are accepted in every state, so a byte arriving
    // during EMIT simply starts the next element.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_shift_nxt = r_shift;

        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
            w_index_nxt = '0;
            w_shift_nxt = '0;
        end else if (bus.rx_valid) begin
            if (w_complete) begin
                w_state_nxt = ST_EMIT;
                w_index_nxt = '0;
                w_shift_nxt = '0;
            end else begin
                w_state_nxt = ST_COLLECT;
                w_index_nxt = r_index + 1'b1;
                w_shift_nxt = w_word;
            end
        end else begin
            case (r_state)
                ST_EMIT: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_COLLECT: begin
                    if (w_tmo_expired) begin
                        w_state_nxt = ST_IDLE;
                        w_index_nxt = '0;
                        w_shift_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Result registers: element only moves on completion, so flush, timeout
    // and partial bytes leave the last good element visible downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_element       <= '0;
            r_count         <= '0;
            r_timeout_error <= 1'b0;
        end else begin
            if (w_complete) begin
                r_element <= w_word;
                r_count   <= r_count + 1'b1;
            end
            if (bus.flush) begin
                r_timeout_error <= 1'b0;
            end else if (w_tmo_expired) begin
                r_timeout_error <= 1'b1;
            end
        end
    end

    // EMIT lasts exactly one cycle per completion, so it doubles as the strobe.
    assign bus.element       = r_element;
    assign bus.element_ready = (r_state == ST_EMIT);
    assign bus.state         = r_state;
    assign bus.element_count = r_count;
    assign bus.timeout_error = r_timeout_error;

endmodule
